parity_frame_rx: RTL and testbench

Serial receiver and checker for the even-parity code produced by the 3-input parity generator (P = X ^ Y ^ Z). It samples a framed serial line (start bit, DATA_BITS data bits, parity bit, stop bit), reassembles the data word, and flags parity and framing errors. It sits at the receive end of the link that carries generator output between boards or between blocks.

---
 rtl/parity_frame_rx_if.sv | 16 +
 rtl/parity_frame_rx.sv | 97 +++++++++
 tb/tb_parity_frame_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/parity_frame_rx_if.sv
// Receive-side bundle for parity_frame_rx: sample enable and serial line in,
// reassembled word and status flags out.
interface parity_frame_rx_if #(
  parameter int DATA_BITS = 3
) ();
  logic                 en;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 perr;
  logic                 ferr;
  logic                 busy;

  modport master (output en, rx, input data, valid, perr, ferr, busy);
  modport slave  (input en, rx, output data, valid, perr, ferr, busy);
endinterface

// File: rtl/parity_frame_rx.sv
// Framed serial receiver (start, DATA_BITS data MSB-first, parity, stop) that
// reassembles the word and flags parity and framing errors.
module parity_frame_rx #(
  parameter int DATA_BITS  = 3,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  parity_frame_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pbit_q, pbit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 err;

  assign err = (^shift_q ^ pbit_q) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pbit_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pbit_q  <= pbit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // valid defaults low every cycle so the pulse never stretches across en=0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pbit_d  = pbit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (bus.en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.rx) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          shift_d    = shift_q << 1;
          shift_d[0] = bus.rx;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_d == CW'(DATA_BITS)) state_d = S_PARITY;
        end
        S_PARITY: begin
          pbit_d  = bus.rx;
          state_d = S_STOP;
        end
        S_STOP: begin
          data_d  = shift_q;
          perr_d  = err;
          ferr_d  = ~bus.rx;
          valid_d = 1'b1;
          state_d = bus.rx ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (bus.rx) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.perr  = perr_q;
  assign bus.ferr  = ferr_q;
  assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: even and odd instances share one line.
module tb_parity_frame_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic rx  = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  parity_frame_rx_if #(.DATA_BITS(3)) bus ();
  parity_frame_rx_if #(.DATA_BITS(3)) bus_o ();

  assign bus.en    = en;
  assign bus.rx    = rx;
  assign bus_o.en  = en;
  assign bus_o.rx  = rx;

  parity_frame_rx #(.DATA_BITS(3), .PARITY_ODD(0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  parity_frame_rx #(.DATA_BITS(3), .PARITY_ODD(1)) u_odd (.clk(clk), .rst(rst), .bus(bus_o));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one sample: set inputs at negedge, return 1 time unit after the posedge
  task automatic drive(input logic b, input logic e);
    @(negedge clk);
    rx = b;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] d, input logic p, input logic s,
                            input logic ep, input logic ef, input string tag);
    drive(1'b0, 1'b1);
    chk({tag, "_busy_start"}, bus.busy, 1);
    for (int i = 2; i >= 0; i--) begin
      drive(d[i], 1'b1);
      chk({tag, "_novalid"}, bus.valid, 0);
    end
    drive(p, 1'b1);
    chk({tag, "_novalid_p"}, bus.valid, 0);
    drive(s, 1'b1);
    chk({tag, "_valid"}, bus.valid, 1);
    chk({tag, "_data"},  bus.data,  d);
    chk({tag, "_perr"},  bus.perr,  ep);
    chk({tag, "_ferr"},  bus.ferr,  ef);
    chk({tag, "_busy"},  bus.busy,  !s);
    chk({tag, "_odd_perr"}, bus_o.perr, !ep);
    chk({tag, "_odd_data"}, bus_o.data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_data",  bus.data,  0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_perr",  bus.perr,  0);
    chk("rst_ferr",  bus.ferr,  0);
    chk("rst_busy",  bus.busy,  0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1);

    // clean even frame 101, parity 0
    send_frame(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, "clean");
    drive(1'b1, 1'b1);
    chk("clean_pulse_end", bus.valid, 0);
    chk("clean_hold_data", bus.data, 3'b101);

    // parity error 110 with parity 1
    send_frame(3'b110, 1'b1, 1'b1, 1'b1, 1'b0, "perr");

    // all data values with correct then inverted parity
    for (int v = 0; v < 8; v++) begin
      logic [2:0] d;
      d = 3'(v);
      send_frame(d, ^d,  1'b1, 1'b0, 1'b0, "sweep_ok");
      send_frame(d, ~^d, 1'b1, 1'b1, 1'b0, "sweep_bad");
    end

    // framing error: data 001, parity 1, stop 0, then a held-low line
    send_frame(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, "ferr");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      chk("brk_busy",  bus.busy,  1);
      chk("brk_valid", bus.valid, 0);
    end
    drive(1'b1, 1'b1);
    chk("brk_exit_busy", bus.busy, 0);
    chk("brk_hold_ferr", bus.ferr, 1);
    drive(1'b1, 1'b1);
    chk("brk_idle_busy", bus.busy, 0);

    // enable gaps: 011 parity 0, en pattern 1,0,0 with junk rx on gaps
    begin
      logic [5:0] bits;
      bits = 6'b0_011_0_1;
      for (int i = 5; i >= 0; i--) begin
        drive(bits[i], 1'b1);
        if (i == 0) begin
          chk("gap_valid", bus.valid, 1);
          chk("gap_data",  bus.data,  3'b011);
          chk("gap_perr",  bus.perr,  0);
          chk("gap_ferr",  bus.ferr,  0);
        end else begin
          chk("gap_early", bus.valid, 0);
        end
        for (int g = 0; g < 2; g++) begin
          drive(~bits[i], 1'b0);
          chk("gap_hold_valid", bus.valid, 0);
        end
      end
      chk("gap_busy", bus.busy, 0);
      chk("gap_hold_data", bus.data, 3'b011);
    end

    // reset mid-frame after second data bit of 111
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    chk("mid_busy", bus.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data", bus.data, 0);
    chk("mid_rst_valid", bus.valid, 0);
    chk("mid_rst_perr", bus.perr, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1);
    chk("mid_idle_valid", bus.valid, 0);
    send_frame(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, "after_rst");

    // back-to-back 100 and 010, both parity 1, no idle between
    send_frame(3'b100, 1'b1, 1'b1, 1'b0, 1'b0, "b2b_a");
    send_frame(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, "b2b_b");
    drive(1'b1, 1'b1);
    chk("b2b_pulse_end", bus.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
